rst_release_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/seq_delay_cnt.sv | 29 ++
 rtl/rst_release_seq.sv | 98 +++++++++
 tb/tb_rst_release_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset-release sequencer: state encoding and counter sizing.
// Latency: n/a (package). Backpressure: n/a.
package rst_seq_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_STAGE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_INIT  = ST_INIT,
        S_STAGE = ST_STAGE,
        S_DONE  = ST_DONE
    } seq_state_t;

    // Wide enough to hold max(init_cyc, stage_cyc)-1 with one bit of headroom.
    function automatic int cnt_width(input int init_cyc, input int stage_cyc);
        int m;
        m = (init_cyc > stage_cyc) ? init_cyc : stage_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/seq_delay_cnt.sv
// Interval counter: counts enabled cycles up to tc, flags hit and wraps to 0; clr/load override.
// Latency: hit is combinational on the terminal cycle. Backpressure: en low freezes the count.
module seq_delay_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc,
    output logic [W-1:0] cnt,
    output logic         hit
);

    assign hit = en && (cnt == tc);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= hit ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/rst_release_seq.sv
// Staged enable release: INIT_CYC after reset, then one channel every STAGE_CYC cycles.
// Latency: ch_en_o[k] after INIT_CYC+k*STAGE_CYC edges. Backpressure: hold_i stretches intervals.
module rst_release_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int INIT_CYC  = 32,
    parameter int STAGE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_i,
    input  logic              hold_i,
    output logic [NUM_CH-1:0] ch_en_o,
    output logic              all_rdy_o,
    output logic              busy_o,
    output logic              seq_done_p
);

    localparam int CNT_W = cnt_width(INIT_CYC, STAGE_CYC);
    localparam int IDX_W = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] INIT_TC  = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc;
    logic             cnt_en;
    logic             hit;

    // The counter idles in DONE so hold_i has no effect there.
    assign cnt_en = (state != S_DONE) && !hold_i;
    assign tc     = (state == S_INIT) ? INIT_TC : STAGE_TC;

    seq_delay_cnt #(
        .W (CNT_W)
    ) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (soft_rst_i),
        .en       (cnt_en),
        .load     (1'b0),
        .load_val ('0),
        .tc       (tc),
        .cnt      (cnt),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (rst || soft_rst_i) begin
            state      <= S_INIT;
            idx        <= '0;
            ch_en_o    <= '0;
            all_rdy_o  <= 1'b0;
            busy_o     <= 1'b1;
            seq_done_p <= 1'b0;
        end else begin
            seq_done_p <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (hit) begin
                        ch_en_o[0] <= 1'b1;
                        idx        <= IDX_W'(1);
                        if (NUM_CH == 1) begin
                            state      <= S_DONE;
                            busy_o     <= 1'b0;
                            all_rdy_o  <= 1'b1;
                            seq_done_p <= 1'b1;
                        end else begin
                            state <= S_STAGE;
                        end
                    end
                end
                S_STAGE: begin
                    if (hit) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx == IDX_W'(i)) ch_en_o[i] <= 1'b1;
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state      <= S_DONE;
                            busy_o     <= 1'b0;
                            all_rdy_o  <= 1'b1;
                            seq_done_p <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: default 4-channel instance plus a 1-channel, 1-cycle instance.
module tb_rst_release_seq;

    logic       clk;
    logic       rst, soft_rst, hold;
    logic [3:0] ch_en;
    logic       all_rdy, busy, done_p;

    logic       rst1, soft_rst1, hold1;
    logic [0:0] ch_en1;
    logic       all_rdy1, busy1, done_p1;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    rst_release_seq dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst_i (soft_rst),
        .hold_i     (hold),
        .ch_en_o    (ch_en),
        .all_rdy_o  (all_rdy),
        .busy_o     (busy),
        .seq_done_p (done_p)
    );

    rst_release_seq #(
        .NUM_CH   (1),
        .INIT_CYC (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .soft_rst_i (soft_rst1),
        .hold_i     (hold1),
        .ch_en_o    (ch_en1),
        .all_rdy_o  (all_rdy1),
        .busy_o     (busy1),
        .seq_done_p (done_p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // Pulse rst for one edge; the next edge becomes edge 1.
    task automatic restart();
        rst = 1'b1;
        step();
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        rst = 1'b1; soft_rst = 1'b0; hold = 1'b0;
        rst1 = 1'b1; soft_rst1 = 1'b0; hold1 = 1'b0;
        repeat (5) step();

        check("rst_ch_en",   32'(ch_en),   32'h0);
        check("rst_all_rdy", 32'(all_rdy), 32'h0);
        check("rst_busy",    32'(busy),    32'h1);
        check("rst_done",    32'(done_p),  32'h0);
        check("rst1_ch_en",  32'(ch_en1),  32'h0);
        check("rst1_busy",   32'(busy1),   32'h1);

        // Nominal sequence
        rst = 1'b0; edge_n = 0;
        run_to(31); check("t1_e31", 32'(ch_en), 32'h0);
        run_to(32); check("t1_e32", 32'(ch_en), 32'h1);
        run_to(47); check("t1_e47", 32'(ch_en), 32'h1);
        run_to(48); check("t1_e48", 32'(ch_en), 32'h3);
        run_to(64); check("t1_e64", 32'(ch_en), 32'h7);
        run_to(79);
        check("t1_e79_ch",   32'(ch_en),  32'h7);
        check("t1_e79_done", 32'(done_p), 32'h0);
        check("t1_e79_busy", 32'(busy),   32'h1);
        run_to(80);
        check("t1_e80_ch",   32'(ch_en),   32'hf);
        check("t1_e80_done", 32'(done_p),  32'h1);
        check("t1_e80_rdy",  32'(all_rdy), 32'h1);
        check("t1_e80_busy", 32'(busy),    32'h0);
        run_to(81);
        check("t1_e81_done", 32'(done_p),  32'h0);
        check("t1_e81_rdy",  32'(all_rdy), 32'h1);

        // Hold for edges 40..49
        restart();
        run_to(39); hold = 1'b1;
        run_to(45); check("t2_hold_e45", 32'(ch_en), 32'h1);
        run_to(49); check("t2_hold_e49", 32'(ch_en), 32'h1);
        hold = 1'b0;
        run_to(57); check("t2_e57", 32'(ch_en), 32'h1);
        run_to(58); check("t2_e58", 32'(ch_en), 32'h3);
        run_to(89); check("t2_e89", 32'(ch_en), 32'h7);
        run_to(90);
        check("t2_e90_ch",   32'(ch_en),  32'hf);
        check("t2_e90_done", 32'(done_p), 32'h1);

        // Soft restart pulse at edge 60
        restart();
        run_to(59); check("t3_e59", 32'(ch_en), 32'h3);
        soft_rst = 1'b1;
        run_to(60);
        soft_rst = 1'b0;
        check("t3_e60_ch",   32'(ch_en), 32'h0);
        check("t3_e60_busy", 32'(busy),  32'h1);
        run_to(91);  check("t3_e91",  32'(ch_en), 32'h0);
        run_to(92);  check("t3_e92",  32'(ch_en), 32'h1);
        run_to(139);
        check("t3_e139_rdy",  32'(all_rdy), 32'h0);
        check("t3_e139_done", 32'(done_p),  32'h0);
        run_to(140);
        check("t3_e140_rdy",  32'(all_rdy), 32'h1);
        check("t3_e140_done", 32'(done_p),  32'h1);
        run_to(141); check("t3_e141_done", 32'(done_p), 32'h0);

        // rst asserted for edges 50..52
        restart();
        run_to(49); rst = 1'b1;
        run_to(50);
        check("t4_e50_ch",   32'(ch_en),   32'h0);
        check("t4_e50_busy", 32'(busy),    32'h1);
        check("t4_e50_rdy",  32'(all_rdy), 32'h0);
        run_to(52); rst = 1'b0;
        run_to(83);  check("t4_e83", 32'(ch_en), 32'h0);
        run_to(84);  check("t4_e84", 32'(ch_en), 32'h1);
        run_to(132); check("t4_e132_rdy", 32'(all_rdy), 32'h1);

        // Soft reset plus hold while in DONE; counter must stay at 0 through the hold
        run_to(133); soft_rst = 1'b1; hold = 1'b1;
        run_to(134);
        check("t6_ch",   32'(ch_en),   32'h0);
        check("t6_busy", 32'(busy),    32'h1);
        check("t6_rdy",  32'(all_rdy), 32'h0);
        run_to(138); soft_rst = 1'b0;
        run_to(148); check("t6_hold_ch", 32'(ch_en), 32'h0);
        hold = 1'b0;
        run_to(179); check("t6_e31", 32'(ch_en), 32'h0);
        run_to(180); check("t6_e32", 32'(ch_en), 32'h1);

        // Single channel, single-cycle init delay
        rst1 = 1'b0;
        step();
        check("t5_ch",   32'(ch_en1),   32'h1);
        check("t5_rdy",  32'(all_rdy1), 32'h1);
        check("t5_done", 32'(done_p1),  32'h1);
        check("t5_busy", 32'(busy1),    32'h0);
        step();
        check("t5_done_fall", 32'(done_p1), 32'h0);
        check("t5_ch_hold",   32'(ch_en1),  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
